coherence_bus_ctrl: RTL and testbench
=====================================

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 2, meaning number of caches served; index i is the requester and j = 1-i is the other cache.
REQ-002 SHALL have the following ports:
- CLK  in  1  bus clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN, dREN, dWEN  in  [CPUS-1:0]  per-cache instruction read, data read and data write requests.
- iaddr, daddr, dstore  in  [CPUS-1:0] word_t  per-cache addresses and store data.
- ccwrite, cctrans  in  [CPUS-1:0]  requester write intent; cache state transitioning.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- iwait, dwait  out  [CPUS-1:0]  stall to each cache; low means the word completed this cycle.
- iload, dload  out  [CPUS-1:0] word_t  load data to each cache.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  word_t  RAM address and write data.
- ccwait, ccinv  out  [CPUS-1:0]  snoop stall and invalidate to each cache.
- ccsnoopaddr  out  [CPUS-1:0] word_t  snoop address.

Function
REQ-003 SHALL implement the FSM states IDLE, IFETCH, DWB1, DWB2, SNOOP, LOAD1, LOAD2, C2C1, C2C2; block size is 2 words.
REQ-004 IDLE SHALL grant at most one request per cycle: dWEN first, then dREN, then iREN.
REQ-005 Within the same request class, ties between caches SHALL go round-robin to the cache not served last; the pointer updates on every grant.
REQ-006 Grant transitions SHALL be:
- dWEN -> DWB1 -> DWB2 -> IDLE.
- dREN -> SNOOP.
- iREN -> IFETCH -> IDLE.
REQ-007 In IFETCH and DWB1/2, ramaddr SHALL equal the granted cache's iaddr/daddr, and ramREN/ramWEN SHALL be asserted; ramstore SHALL be dstore[i].
REQ-008 Each word SHALL complete only in a cycle with ramstate==ACCESS.
- On completion, the granted iwait/dwait is low for exactly that cycle, and iload/dload[i] = ramload.
- On completion the FSM advances to the next state.
REQ-009 SNOOP SHALL hold ccwait[j]=1, ccsnoopaddr[j]=daddr[i] and ccinv[j]=ccwrite[i] for one cycle.
- Next state is C2C1 if dWEN[j] is high, otherwise LOAD1.
REQ-010 LOAD1/LOAD2 SHALL read daddr[i] from RAM per REQ-008; ccwait[j] stays high.
REQ-011 C2C1/C2C2 (cache-to-cache) SHALL, per word:
- Drive dload[i]=dstore[j] and write it to RAM (ramWEN=1, ramaddr=daddr[j]).
- On ACCESS, drive dwait[i] and dwait[j] low together.
- Keep ccwait[j] high throughout.
REQ-012 When ramstate is ERROR or BUSY, the FSM SHALL hold state with all waits high.
REQ-013 ramREN and ramWEN SHALL never be high in the same cycle.
REQ-014 ccwait/ccinv SHALL be 0 in IDLE, IFETCH and DWB states.
REQ-015 If a requester drops its request mid-transaction, the FSM SHALL return to IDLE on the next cycle with RAM strobes low.
REQ-016 Any iwait/dwait not named active in a given state SHALL be 1.
REQ-017 In every cycle not otherwise specified:
- iload/dload SHALL be ramload.
- ccsnoopaddr[j] SHALL be daddr[i].

Reset
REQ-018 While RST is high at a CLK edge, the FSM SHALL enter IDLE and the round-robin pointer SHALL clear to 0.
REQ-019 During and after reset, outputs SHALL be:
- iwait=dwait='1, ccwait=ccinv=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction with no further RAM strobes.

Structure
REQ-021 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-022 The bus-state enum SHALL be added to cpu_types_pkg as busstate_t.
REQ-023 Round-robin selection SHALL be a sub-module, rr_arbiter (2 requesters, registered last-grant).

Verification
REQ-024 The bench SHALL cover these scenarios:
- iREN[0]=1, iaddr=0x100, ACCESS after 2 BUSY cycles -> iwait[0] low in cycle 3 with iload[0]=ramload; ramREN high for all 3 cycles.
- iREN[0]=iREN[1]=1 held -> grants alternate 0,1,0,1.
- dWEN[1]=1 and iREN[0]=1 together -> DWB1/DWB2 for cache 1 (ramWEN, ramstore=dstore[1]) precede IFETCH for cache 0.
- dREN[0]=1, ccwrite[0]=1, daddr=0x200, dWEN[1]=0 -> SNOOP cycle with ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x200, then 2 RAM reads.
- dREN[0]=1 with dWEN[1]=1, dstore[1]=0xDEAD -> dload[0]=0xDEAD, ramWEN=1, ramaddr=daddr[1], dwait[0] and dwait[1] low together, twice.
- RST asserted in LOAD2 -> next cycle IDLE, all waits high, strobes low.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state and coherence bus FSM states.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [3:0] {
        IDLE,
        IFETCH,
        DWB1,
        DWB2,
        SNOOP,
        LOAD1,
        LOAD2,
        C2C1,
        C2C2
    } busstate_t;

    function automatic logic ram_stalled(input ramstate_t rs);
        return (rs == BUSY) || (rs == ERROR);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Two-requester round-robin picker; ptr names the cache favoured on the next tie,
// so it always holds the complement of the most recent grant.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt,
    output logic       valid
);
    logic ptr;

    always_comb begin
        valid = |req;
        gnt   = (req == 2'b11) ? ptr : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (take && valid) begin
            ptr <= ~gnt;
        end
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping bus controller: arbitrates instruction fetches, write-backs and
// coherent data reads, serving reads from RAM or directly from the other cache.
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     iaddr,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     iload,
    output word_t [CPUS-1:0]     dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output word_t [CPUS-1:0]     ccsnoopaddr
);
    busstate_t       state;
    busstate_t       next_state;
    busstate_t       grant_state;
    logic            cur;
    logic            oth;
    logic            stall;
    logic            done;
    logic            take;
    logic            gnt;
    logic            req_valid;
    logic [CPUS-1:0] class_req;
    logic            unused_cctrans;

    assign oth            = ~cur;
    assign stall          = ram_stalled(ramstate);
    assign done           = (ramstate == ACCESS);
    assign take           = (state == IDLE) && !stall;
    assign unused_cctrans = ^cctrans;

    // Request class priority: write-backs, then coherent reads, then fetches.
    always_comb begin
        if (|dWEN) begin
            class_req   = dWEN;
            grant_state = DWB1;
        end else if (|dREN) begin
            class_req   = dREN;
            grant_state = SNOOP;
        end else begin
            class_req   = iREN;
            grant_state = IFETCH;
        end
    end

    rr_arbiter u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req   (class_req),
        .take  (take),
        .gnt   (gnt),
        .valid (req_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cur   <= 1'b0;
        end else begin
            state <= next_state;
            if (take && req_valid) begin
                cur <= gnt;
            end
        end
    end

    always_comb begin
        next_state = state;
        iwait      = '1;
        dwait      = '1;
        iload      = {CPUS{ramload}};
        dload      = {CPUS{ramload}};
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        ccwait     = '0;
        ccinv      = '0;
        for (int c = 0; c < CPUS; c++) begin
            ccsnoopaddr[c] = daddr[CPUS-1-c];
        end

        case (state)
            IDLE: begin
                if (!stall && req_valid) begin
                    next_state = grant_state;
                end
            end
            IFETCH: begin
                if (!iREN[cur]) begin
                    next_state = IDLE;
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = iaddr[cur];
                    ramstore = dstore[cur];
                    if (done) begin
                        iwait[cur] = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            DWB1, DWB2: begin
                if (!dWEN[cur]) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[cur];
                    ramstore = dstore[cur];
                    if (done) begin
                        dwait[cur] = 1'b0;
                        next_state = (state == DWB1) ? DWB2 : IDLE;
                    end
                end
            end
            SNOOP: begin
                if (!dREN[cur]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[oth] = 1'b1;
                    ccinv[oth]  = ccwrite[cur];
                    if (!stall) begin
                        next_state = dWEN[oth] ? C2C1 : LOAD1;
                    end
                end
            end
            LOAD1, LOAD2: begin
                if (!dREN[cur]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[oth] = 1'b1;
                    ramREN      = 1'b1;
                    ramaddr     = daddr[cur];
                    if (done) begin
                        dwait[cur] = 1'b0;
                        next_state = (state == LOAD1) ? LOAD2 : IDLE;
                    end
                end
            end
            C2C1, C2C2: begin
                // The other cache's dirty block goes to the requester and to RAM at once.
                if (!dREN[cur]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[oth] = 1'b1;
                    ramWEN      = 1'b1;
                    ramaddr     = daddr[oth];
                    ramstore    = dstore[oth];
                    dload[cur]  = dstore[oth];
                    if (done) begin
                        dwait[cur] = 1'b0;
                        dwait[oth] = 1'b0;
                        next_state = (state == C2C1) ? C2C2 : IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        // Reset silences the bus in the same cycle so an aborted transfer issues no strobe.
        if (RST) begin
            iwait    = '1;
            dwait    = '1;
            dload    = {CPUS{ramload}};
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            ccwait   = '0;
            ccinv    = '0;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: directed bus scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level model of the bus.
module tb_coherence_bus_ctrl;
    import cpu_types_pkg::*;

    localparam int K_I = 0;
    localparam int K_W = 1;
    localparam int K_R = 2;

    logic          CLK;
    logic          RST;
    logic [1:0]    iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [1:0]   iaddr, daddr, dstore;
    word_t         ramload;
    ramstate_t     ramstate;
    logic [1:0]    iwait, dwait, ccwait, ccinv;
    word_t [1:0]   iload, dload, ccsnoopaddr;
    logic          ramREN, ramWEN;
    word_t         ramaddr, ramstore;

    logic [1:0]    exp_iwait, exp_dwait, exp_ccwait, exp_ccinv;
    word_t [1:0]   exp_iload, exp_dload, exp_snoop;
    logic          exp_ren, exp_wen;
    word_t         exp_addr, exp_store;

    logic [1:0]    s_iwait, s_dwait, s_ccwait, s_ccinv;
    word_t [1:0]   s_iload, s_dload, s_snoop;
    logic          s_ren, s_wen;
    word_t         s_addr, s_store;

    bit            m_busy;
    int            m_kind, m_i, m_left, m_rr;
    bit            m_snooped, m_c2c;

    int            n_cmp;
    int            n_bad;

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .iaddr       (iaddr),
        .daddr       (daddr),
        .dstore      (dstore),
        .ccwrite     (ccwrite),
        .cctrans     (cctrans),
        .ramload     (ramload),
        .ramstate    (ramstate),
        .iwait       (iwait),
        .dwait       (dwait),
        .iload       (iload),
        .dload       (dload),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Transaction-level view: one active transfer with a word count, picked by class then fairness.
    task automatic model_cycle();
        bit         stall, acc, held;
        int         j, g;
        logic [1:0] vec;
        stall      = (ramstate == BUSY) || (ramstate == ERROR);
        acc        = (ramstate == ACCESS);
        exp_iwait  = 2'b11;
        exp_dwait  = 2'b11;
        exp_iload  = {ramload, ramload};
        exp_dload  = {ramload, ramload};
        exp_ren    = 1'b0;
        exp_wen    = 1'b0;
        exp_addr   = '0;
        exp_store  = '0;
        exp_ccwait = 2'b00;
        exp_ccinv  = 2'b00;
        exp_snoop[0] = daddr[1];
        exp_snoop[1] = daddr[0];
        if (RST) begin
            m_busy = 1'b0;
            m_rr   = 0;
            return;
        end
        if (m_busy) begin
            j    = 1 - m_i;
            held = (m_kind == K_I) ? iREN[m_i] : (m_kind == K_W) ? dWEN[m_i] : dREN[m_i];
            if (!held) begin
                m_busy = 1'b0;
            end else if (m_kind == K_I) begin
                exp_ren   = 1'b1;
                exp_addr  = iaddr[m_i];
                exp_store = dstore[m_i];
                if (acc) begin
                    exp_iwait[m_i] = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_kind == K_W) begin
                exp_wen   = 1'b1;
                exp_addr  = daddr[m_i];
                exp_store = dstore[m_i];
                if (acc) begin
                    exp_dwait[m_i] = 1'b0;
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end
            end else begin
                exp_ccwait[j] = 1'b1;
                if (!m_snooped) begin
                    exp_ccinv[j] = ccwrite[m_i];
                    if (!stall) begin
                        m_snooped = 1'b1;
                        m_c2c     = dWEN[j];
                        m_left    = 2;
                    end
                end else begin
                    if (m_c2c) begin
                        exp_wen        = 1'b1;
                        exp_addr       = daddr[j];
                        exp_store      = dstore[j];
                        exp_dload[m_i] = dstore[j];
                    end else begin
                        exp_ren  = 1'b1;
                        exp_addr = daddr[m_i];
                    end
                    if (acc) begin
                        exp_dwait[m_i] = 1'b0;
                        if (m_c2c) exp_dwait[j] = 1'b0;
                        m_left--;
                        if (m_left == 0) m_busy = 1'b0;
                    end
                end
            end
        end else if (!stall) begin
            vec = (|dWEN) ? dWEN : (|dREN) ? dREN : iREN;
            if (vec != 2'b00) begin
                g         = (vec == 2'b11) ? m_rr : (vec[1] ? 1 : 0);
                m_rr      = 1 - g;
                m_busy    = 1'b1;
                m_i       = g;
                m_kind    = (|dWEN) ? K_W : (|dREN) ? K_R : K_I;
                m_left    = 2;
                m_snooped = 1'b0;
                m_c2c     = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        s_iwait  = iwait;
        s_dwait  = dwait;
        s_iload  = iload;
        s_dload  = dload;
        s_ren    = ramREN;
        s_wen    = ramWEN;
        s_addr   = ramaddr;
        s_store  = ramstore;
        s_ccwait = ccwait;
        s_ccinv  = ccinv;
        s_snoop  = ccsnoopaddr;
        model_cycle();
        check_val("iwait",    64'(s_iwait),  64'(exp_iwait));
        check_val("dwait",    64'(s_dwait),  64'(exp_dwait));
        check_val("iload",    64'(s_iload),  64'(exp_iload));
        check_val("dload",    64'(s_dload),  64'(exp_dload));
        check_val("ramREN",   64'(s_ren),    64'(exp_ren));
        check_val("ramWEN",   64'(s_wen),    64'(exp_wen));
        check_val("ramaddr",  64'(s_addr),   64'(exp_addr));
        check_val("ramstore", 64'(s_store),  64'(exp_store));
        check_val("ccwait",   64'(s_ccwait), 64'(exp_ccwait));
        check_val("ccinv",    64'(s_ccinv),  64'(exp_ccinv));
        check_val("snoopadr", 64'(s_snoop),  64'(exp_snoop));
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'h0; ramstate = FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_busy = 1'b0; m_kind = 0; m_i = 0; m_left = 0; m_rr = 0;
        m_snooped = 1'b0; m_c2c = 1'b0;
        clear_inputs();
        RST = 1'b1;
        #1;
        do_reset();
        check_val("rst_iwait", 64'(s_iwait), 64'(2'b11));
        check_val("rst_strb",  64'({s_ren, s_wen}), 64'(2'b00));

        // Fetch with two BUSY cycles before ACCESS.
        iREN = 2'b01; iaddr[0] = 32'h100; ramload = 32'h1234_5678;
        step();
        ramstate = BUSY;
        step();
        check_val("if_busy1", 64'({s_ren, s_iwait}), 64'(3'b111));
        check_val("if_addr",  64'(s_addr), 64'(32'h100));
        step();
        check_val("if_busy2", 64'({s_ren, s_iwait}), 64'(3'b111));
        ramstate = ACCESS;
        step();
        check_val("if_done",  64'({s_ren, s_iwait}), 64'(3'b110));
        check_val("if_load",  64'(s_iload[0]), 64'(32'h1234_5678));
        iREN = 2'b00;
        step();

        // Tied fetches alternate starting from cache 0.
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h40; iaddr[1] = 32'h80; ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            check_val("rr_grant", 64'(s_iwait), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
        end
        clear_inputs();
        step();

        // Write-back outranks a simultaneous fetch.
        dWEN = 2'b10; iREN = 2'b01; daddr[1] = 32'h300; dstore[1] = 32'hCAFE_0001;
        iaddr[0] = 32'h500; ramstate = ACCESS;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("dwb_wen",   64'({s_wen, s_ren}), 64'(2'b10));
            check_val("dwb_store", 64'(s_store), 64'(32'hCAFE_0001));
            check_val("dwb_dwait", 64'(s_dwait), 64'(2'b01));
        end
        dWEN = 2'b00;
        step();
        step();
        check_val("dwb_then_if", 64'({s_ren, s_iwait}), 64'(3'b110));
        check_val("dwb_if_addr", 64'(s_addr), 64'(32'h500));
        clear_inputs();
        step();

        // Coherent read with invalidate, served from RAM.
        dREN = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h200; ramstate = ACCESS;
        step();
        step();
        check_val("snp_ccwait", 64'(s_ccwait), 64'(2'b10));
        check_val("snp_ccinv",  64'(s_ccinv), 64'(2'b10));
        check_val("snp_addr",   64'(s_snoop[1]), 64'(32'h200));
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("ld_read", 64'({s_ren, s_dwait}), 64'(3'b110));
            check_val("ld_addr", 64'(s_addr), 64'(32'h200));
        end
        clear_inputs();
        step();

        // Coherent read served cache-to-cache.
        dREN = 2'b01; daddr[0] = 32'h600; daddr[1] = 32'h400; ramstate = ACCESS;
        step();
        dWEN = 2'b10; dstore[1] = 32'h0000_DEAD;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("c2c_dload", 64'(s_dload[0]), 64'(32'h0000_DEAD));
            check_val("c2c_wen",   64'({s_wen, s_ren, s_dwait}), 64'(4'b1000));
            check_val("c2c_addr",  64'(s_addr), 64'(32'h400));
        end
        clear_inputs();
        step();

        // Reset arriving in the second load word.
        dREN = 2'b01; daddr[0] = 32'h700; ramstate = ACCESS;
        step();
        step();
        step();
        RST = 1'b1;
        step();
        check_val("rst_mid", 64'({s_ren, s_wen, s_iwait, s_dwait}), 64'(6'b001111));
        RST = 1'b0; dREN = 2'b00;
        step();
        check_val("post_rst", 64'({s_ren, s_wen, s_iwait, s_dwait, s_ccwait}), 64'(8'b00111100));

        // Randomized traffic with sticky requests.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 11) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(0, 11) == 0) dREN[c] = ~dREN[c];
                if ($urandom_range(0, 15) == 0) dWEN[c] = ~dWEN[c];
                iaddr[c]  = $urandom;
                daddr[c]  = $urandom;
                dstore[c] = $urandom;
            end
            ccwrite = 2'($urandom);
            cctrans = 2'($urandom);
            ramload = $urandom;
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: ramstate = ACCESS;
                10, 11, 12, 13, 14:          ramstate = BUSY;
                15, 16, 17:                  ramstate = FREE;
                default:                     ramstate = ERROR;
            endcase
            RST = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
